alloc_sched: RTL and testbench

Frame-level allocation scheduler for the receive phase-tracking stage. It holds a bank of 400-bit subcarrier allocation patterns, written over a Wishbone configuration port. It presents one pattern per OFDM symbol on `ALLOC_VEC`, advancing each time the consumer pulses `VEC_LD`. Writes land in a shadow bank and are committed atomically at frame boundaries, so a running frame never sees a torn vector.

---
 rtl/alloc_sched_if.sv | 14 +
 rtl/alloc_sched.sv | 198 +++++++++++++++++++
 tb/tb_alloc_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alloc_sched_if.sv
// Wishbone configuration bus shared between the host (master) and alloc_sched (slave).
`timescale 1ns/1ps
interface alloc_sched_if;
  logic [6:0]  ADR_I;
  logic [31:0] DAT_I;
  logic        WE_I;
  logic        STB_I;
  logic        CYC_I;
  logic        ACK_O;
  logic [31:0] DAT_O;

  modport master (output ADR_I, DAT_I, WE_I, STB_I, CYC_I, input ACK_O, DAT_O);
  modport slave  (input ADR_I, DAT_I, WE_I, STB_I, CYC_I, output ACK_O, DAT_O);
endinterface

// File: rtl/alloc_sched.sv
// Frame-level allocation scheduler: shadow/active pattern banks, one 400-bit
// allocation vector per OFDM symbol, commits applied only at frame boundaries.
//
// state  | meaning
// S_IDLE | between frames; ALLOC_VEC shows active pattern 0, pending commits apply
// S_RUN  | frame in progress; VEC_LD steps the symbol index and pattern rotation
`timescale 1ns/1ps
module alloc_sched #(
  parameter int PAT_NUM = 4
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  alloc_sched_if.slave wb,
  input  logic         FRM_START,
  input  logic         VEC_LD,
  output logic [399:0] ALLOC_VEC,
  output logic [7:0]   SYM_IDX,
  output logic         FRM_END,
  output logic         OVR
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state, w_state_nxt;
  // Banks are sized for the maximum pattern count; entries >= PAT_NUM are never written.
  logic [399:0] r_shadow [4];
  logic [399:0] r_active [4];
  logic         r_ack;
  logic [31:0]  r_dat;
  logic [7:0]   r_flen;
  logic [7:0]   r_sym;
  logic [1:0]   r_pidx;
  logic         r_pend;
  logic         r_ovr;
  logic         r_frm_end;
  logic [399:0] r_vec;

  logic         w_acc, w_wr, w_pat_sel, w_p_ok;
  logic [1:0]   w_p;
  logic [3:0]   w_w;
  logic [8:0]   w_ofs;
  logic         w_commit_wr, w_status_wr, w_flen_wr;
  logic [7:0]   w_flen_eff;
  logic         w_last;
  logic [1:0]   w_pidx_nxt;
  logic [31:0]  w_rd;
  logic         w_start, w_adv, w_end, w_copy;

  assign w_acc       = wb.STB_I & wb.CYC_I & ~r_ack;
  assign w_wr        = w_acc & wb.WE_I;
  assign w_pat_sel   = ~wb.ADR_I[6];
  assign w_p         = wb.ADR_I[5:4];
  assign w_w         = wb.ADR_I[3:0];
  assign w_ofs       = {w_w, 5'b0};
  assign w_p_ok      = (int'(w_p) < PAT_NUM);
  assign w_flen_wr   = w_wr & (wb.ADR_I == 7'h40);
  assign w_commit_wr = w_wr & (wb.ADR_I == 7'h41) & wb.DAT_I[0];
  assign w_status_wr = w_wr & (wb.ADR_I == 7'h42);
  // A zero frame length behaves as a single-symbol frame.
  assign w_flen_eff  = (r_flen == 8'd0) ? 8'd1 : r_flen;
  assign w_last      = (r_sym >= w_flen_eff - 8'd1);

  assign wb.ACK_O  = r_ack;
  assign wb.DAT_O  = r_dat;
  assign ALLOC_VEC = r_vec;
  assign SYM_IDX   = r_sym;
  assign FRM_END   = r_frm_end;
  assign OVR       = r_ovr;

  // Data patterns rotate through 1..PAT_NUM-1; pattern 0 is reserved for symbol 0.
  always_comb begin
    w_pidx_nxt = r_pidx + 2'd1;
    if (r_pidx == 2'd0 || r_pidx >= 2'(PAT_NUM - 1)) w_pidx_nxt = 2'd1;
  end

  // Configuration read mux: shadow pattern words or control/status registers.
  always_comb begin
    w_rd = '0;
    if (w_pat_sel) begin
      if (w_p_ok) begin
        if (w_w < 4'd12)       w_rd = r_shadow[w_p][w_ofs +: 32];
        else if (w_w == 4'd12) w_rd = {16'h0, r_shadow[w_p][399:384]};
      end
    end else begin
      case (wb.ADR_I)
        7'h40:   w_rd = {24'h0, r_flen};
        7'h42:   w_rd = {29'h0, r_state == S_RUN, r_ovr, r_pend};
        default: w_rd = '0;
      endcase
    end
  end

  // Next state plus the frame strobes that drive the vector and bank registers.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_end       = 1'b0;
    w_copy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (FRM_START) begin
          w_start     = 1'b1;
          w_copy      = r_pend | w_commit_wr;
          w_state_nxt = S_RUN;
        end else if (r_pend) begin
          w_copy = 1'b1;
        end
      end
      S_RUN: begin
        if (FRM_START) begin
          w_start = 1'b1;
          w_copy  = r_pend | w_commit_wr;
        end else if (VEC_LD) begin
          if (w_last) begin
            w_end       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Wishbone ack/read data and configuration registers.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_flen <= 8'd200;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_ack <= wb.STB_I & wb.CYC_I & ~r_ack;
      r_dat <= w_acc ? w_rd : 32'h0;
      if (w_flen_wr) r_flen <= wb.DAT_I[7:0];
      // A commit written while an IDLE copy is in flight stays pending for the next copy.
      if (w_copy)           r_pend <= w_commit_wr & ~w_start;
      else if (w_commit_wr) r_pend <= 1'b1;
      if (w_start && r_state == S_RUN) r_ovr <= 1'b1;
      else if (w_status_wr)            r_ovr <= 1'b0;
    end
  end

  // Shadow writes and the atomic shadow-to-active copy (copy sees the pre-write shadow).
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_wr && w_pat_sel && w_p_ok) begin
        if (w_w < 4'd12)       r_shadow[w_p][w_ofs +: 32]  <= wb.DAT_I;
        else if (w_w == 4'd12) r_shadow[w_p][399:384]     <= wb.DAT_I[15:0];
      end
      if (w_copy) begin
        for (int i = 0; i < 4; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Vector, symbol index, pattern rotation and frame-end pulse.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_vec     <= '0;
      r_sym     <= '0;
      r_pidx    <= '0;
      r_frm_end <= 1'b0;
    end else begin
      r_frm_end <= w_end;
      if (w_start) begin
        r_vec  <= w_copy ? r_shadow[0] : r_active[0];
        r_sym  <= '0;
        r_pidx <= '0;
      end else if (w_adv) begin
        r_vec  <= r_active[w_pidx_nxt];
        r_sym  <= r_sym + 8'd1;
        r_pidx <= w_pidx_nxt;
      end else if (w_end) begin
        r_vec  <= r_active[0];
        r_sym  <= '0;
        r_pidx <= '0;
      end else if (w_copy) begin
        r_vec <= r_shadow[0];
      end
    end
  end

endmodule

// File: tb/tb_alloc_sched.sv
// Directed bench for alloc_sched: a PAT_NUM=4 instance for the main frame flow
// and a PAT_NUM=2 instance for short-frame and rotation corner cases.
`timescale 1ns/1ps
module tb_alloc_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic frm_start, vec_ld;
  alloc_sched_if bus_a ();
  alloc_sched_if bus_b ();
  logic [399:0] vec_a, vec_b;
  logic [7:0]   sym_a, sym_b;
  logic         end_a, end_b, ovr_a, ovr_b;

  alloc_sched #(.PAT_NUM(4)) dut_a (
    .CLK_I(clk), .RST_I(rst_n), .wb(bus_a), .FRM_START(frm_start), .VEC_LD(vec_ld),
    .ALLOC_VEC(vec_a), .SYM_IDX(sym_a), .FRM_END(end_a), .OVR(ovr_a));

  alloc_sched #(.PAT_NUM(2)) dut_b (
    .CLK_I(clk), .RST_I(rst_n), .wb(bus_b), .FRM_START(frm_start), .VEC_LD(vec_ld),
    .ALLOC_VEC(vec_b), .SYM_IDX(sym_b), .FRM_END(end_b), .OVR(ovr_b));

  localparam logic [399:0] P0 = {50{8'h55}};
  localparam logic [399:0] P1 = {50{8'hAA}};
  localparam logic [399:0] P2 = {50{8'h0F}};
  localparam logic [399:0] P3 = {50{8'hF0}};

  int errors = 0;
  int checks = 0;
  logic [31:0]  rdat;
  logic [399:0] exp_vec;
  logic [399:0] seq_a [5];

  task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus_a.STB_I = 1'b0; bus_a.CYC_I = 1'b0; bus_a.WE_I = 1'b0;
    bus_b.STB_I = 1'b0; bus_b.CYC_I = 1'b0; bus_b.WE_I = 1'b0;
  endtask

  // Both instances see the same bus cycle; read data is taken from the selected one.
  task automatic wb_xfer(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                         input bit from_b, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(posedge clk); #1;
    bus_a.ADR_I = adr; bus_a.DAT_I = dat; bus_a.WE_I = we; bus_a.STB_I = 1'b1; bus_a.CYC_I = 1'b1;
    bus_b.ADR_I = adr; bus_b.DAT_I = dat; bus_b.WE_I = we; bus_b.STB_I = 1'b1; bus_b.CYC_I = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if ((from_b ? bus_b.ACK_O : bus_a.ACK_O) === 1'b1) begin
        got = 1'b1;
        rd  = from_b ? bus_b.DAT_O : bus_a.DAT_O;
      end
    end
    bus_idle();
    chk32("wb_ack", {31'h0, got}, 32'h1);
  endtask

  task automatic wr(input logic [6:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, dat, 1'b0, dummy);
  endtask

  task automatic rd(input logic [6:0] adr, input bit from_b, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, from_b, d);
  endtask

  task automatic wr_pat(input logic [1:0] p, input logic [399:0] val);
    logic [415:0] t;
    logic [3:0]   wv;
    t = {16'h0, val};
    for (int w = 0; w < 13; w++) begin
      wv = 4'(w);
      wr({1'b0, p, wv}, t[32*w +: 32]);
    end
  endtask

  task automatic pulse(input logic fs, input logic vl);
    @(posedge clk); #1;
    frm_start = fs; vec_ld = vl;
    @(posedge clk); #1;
    frm_start = 1'b0; vec_ld = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    seq_a[0] = P1; seq_a[1] = P2; seq_a[2] = P3; seq_a[3] = P1; seq_a[4] = P2;
    rst_n = 1'b0; frm_start = 1'b0; vec_ld = 1'b0;
    bus_a.ADR_I = '0; bus_a.DAT_I = '0; bus_b.ADR_I = '0; bus_b.DAT_I = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", vec_a, '0);
    chk32("rst_sym", {24'h0, sym_a}, 32'h0);
    chk32("rst_end", {31'h0, end_a}, 32'h0);
    chk32("rst_ovr", {31'h0, ovr_a}, 32'h0);
    chk32("rst_ack", {31'h0, bus_a.ACK_O}, 32'h0);
    chk32("rst_dat", bus_a.DAT_O, 32'h0);
    rst_n = 1'b1;
    rd(7'h40, 1'b0, rdat);
    chk32("rst_flen", rdat, 32'd200);

    // Load four patterns, frame length 6, commit in IDLE.
    wr_pat(2'd0, P0); wr_pat(2'd1, P1); wr_pat(2'd2, P2); wr_pat(2'd3, P3);
    wr(7'h40, 32'd6);
    wr(7'h41, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_commit_vec", vec_a, P0);
    rd(7'h42, 1'b0, rdat);
    chk32("idle_status", rdat, 32'h0);

    pulse(1'b1, 1'b0);
    chk32("f1_sym0", {24'h0, sym_a}, 32'h0);
    chk("f1_vec0", vec_a, P0);
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, 1'b1);
      chk32("f1_sym", {24'h0, sym_a}, 32'(i + 1));
      chk("f1_vec", vec_a, seq_a[i]);
      chk32("f1_noend", {31'h0, end_a}, 32'h0);
    end
    pulse(1'b0, 1'b1);
    chk32("f1_end", {31'h0, end_a}, 32'h1);
    chk32("f1_end_sym", {24'h0, sym_a}, 32'h0);
    chk("f1_end_vec", vec_a, P0);
    @(posedge clk); #1;
    chk32("f1_end_pulse", {31'h0, end_a}, 32'h0);
    rd(7'h42, 1'b0, rdat);
    chk32("f1_idle_status", rdat, 32'h0);

    // Commit during RUN stays pending until the next frame.
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk("f2_sym1_vec", vec_a, P1);
    wr_pat(2'd1, '0);
    wr(7'h41, 32'h1);
    rd(7'h42, 1'b0, rdat);
    chk32("f2_pending", rdat, 32'h5);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk32("f2_sym4", {24'h0, sym_a}, 32'd4);
    chk("f2_old_p1", vec_a, P1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk32("f2_end", {31'h0, end_a}, 32'h1);
    pulse(1'b1, 1'b0);
    rd(7'h42, 1'b0, rdat);
    chk32("f3_applied_status", rdat, 32'h4);
    pulse(1'b0, 1'b1);
    chk("f3_new_p1", vec_a, '0);

    // Frame restart with simultaneous VEC_LD at sym 3.
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk32("f3_sym3", {24'h0, sym_a}, 32'd3);
    pulse(1'b1, 1'b1);
    chk32("restart_sym", {24'h0, sym_a}, 32'h0);
    chk("restart_vec", vec_a, P0);
    chk32("restart_ovr", {31'h0, ovr_a}, 32'h1);
    rd(7'h42, 1'b0, rdat);
    chk32("ovr_status", rdat, 32'h6);
    wr(7'h42, 32'h0);
    chk32("ovr_cleared", {31'h0, ovr_a}, 32'h0);

    // Word 12 keeps only 16 bits; word 13 is discarded.
    wr(7'h0C, 32'hDEAD_BEEF);
    rd(7'h0C, 1'b0, rdat);
    chk32("w12_readback", rdat, 32'h0000_BEEF);
    wr(7'h0D, 32'h1234_5678);
    rd(7'h0D, 1'b0, rdat);
    chk32("w13_readback", rdat, 32'h0);
    wr(7'h41, 32'h1);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk32("f4_end", {31'h0, end_a}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    exp_vec = P0;
    exp_vec[399:384] = 16'hBEEF;
    chk("w12_active", vec_a, exp_vec);
    rd(7'h00, 1'b0, rdat);
    chk32("w0_readback", rdat, 32'h5555_5555);

    // Asynchronous reset in the middle of a frame.
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk32("pre_rst_sym", {24'h0, sym_a}, 32'd2);
    chk("pre_rst_vec", vec_a, P2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vec", vec_a, '0);
    chk32("arst_sym", {24'h0, sym_a}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(7'h40, 1'b0, rdat);
    chk32("arst_flen", rdat, 32'd200);
    rd(7'h42, 1'b0, rdat);
    chk32("arst_status", rdat, 32'h0);
    pulse(1'b0, 1'b1);
    chk32("idle_vecld_sym", {24'h0, sym_a}, 32'h0);
    chk32("idle_vecld_end", {31'h0, end_a}, 32'h0);

    // PAT_NUM = 2 instance: zero frame length and single-pattern rotation.
    wr_pat(2'd0, P0);
    wr_pat(2'd1, P1);
    wr(7'h20, 32'h1234_5678);
    rd(7'h20, 1'b1, rdat);
    chk32("b_p2_ignored", rdat, 32'h0);
    wr(7'h40, 32'd0);
    wr(7'h41, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("b_commit_vec", vec_b, P0);
    pulse(1'b1, 1'b0);
    chk32("b_run_sym", {24'h0, sym_b}, 32'h0);
    pulse(1'b0, 1'b1);
    chk32("b_len0_end", {31'h0, end_b}, 32'h1);
    chk32("b_len0_sym", {24'h0, sym_b}, 32'h0);
    chk("b_len0_vec", vec_b, P0);
    wr(7'h40, 32'd4);
    pulse(1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      pulse(1'b0, 1'b1);
      chk32("b_sym", {24'h0, sym_b}, 32'(i));
      chk("b_vec", vec_b, P1);
      chk32("b_noend", {31'h0, end_b}, 32'h0);
    end
    pulse(1'b0, 1'b1);
    chk32("b_len4_end", {31'h0, end_b}, 32'h1);
    chk("b_len4_vec", vec_b, P0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
